// File: rtl/multi_queue_rr_reader.sv
// Round-robin reader that merges QUEUE_COUNT valid/ready beat streams into one registered output.
// Optional packet locking (hold the grant until in_last) is enabled by MULTI_QUEUE_RR_READER_PACKET_LOCK_EN.
module multi_queue_rr_reader #(
    parameter int QUEUE_COUNT = 4,
    parameter int WIDTH       = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [QUEUE_COUNT-1:0]                in_valid,
    input  logic [QUEUE_COUNT-1:0][WIDTH-1:0]     in_payload,
    input  logic [QUEUE_COUNT-1:0]                in_last,
    output logic [QUEUE_COUNT-1:0]                in_ready,
    output logic                                  out_valid,
    output logic [WIDTH-1:0]                      out_payload,
    output logic                                  out_last,
    output logic [$clog2(QUEUE_COUNT)-1:0]        out_queue,
    input  logic                                  out_ready
);

    localparam int IDX_W = $clog2(QUEUE_COUNT);

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        if (v == IDX_W'(QUEUE_COUNT - 1)) begin
            wrap_inc = '0;
        end else begin
            wrap_inc = v + IDX_W'(1);
        end
    endfunction

    logic                   out_valid_r;
    logic [WIDTH-1:0]       out_payload_r;
    logic                   out_last_r;
    logic [IDX_W-1:0]       out_queue_r;
    logic [IDX_W-1:0]       ptr_r;
    logic [QUEUE_COUNT-1:0] elig_s;
    logic [QUEUE_COUNT-1:0] ready_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic                   found_s;
    logic                   load_s;
    logic                   accept_s;
    logic                   acc_last_s;

`ifdef MULTI_QUEUE_RR_READER_PACKET_LOCK_EN
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [IDX_W-1:0] lock_idx_r;

    // While locked only the locked queue may be granted.
    always_comb begin
        elig_s = in_valid;
        if (state_r == ST_LOCKED) begin
            elig_s = in_valid & (QUEUE_COUNT'(1) << lock_idx_r);
        end else begin
            elig_s = in_valid;
        end
    end

    // Lock FSM next-state: enter on a non-last beat, leave on a last beat.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !acc_last_s) begin
                    state_s = ST_LOCKED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (accept_s && acc_last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LOCKED;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Lock FSM state, locked queue and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            lock_idx_r <= '0;
            ptr_r      <= '0;
        end else begin
            state_r <= state_s;
            if (accept_s && state_r == ST_IDLE && state_s == ST_LOCKED) begin
                lock_idx_r <= grant_idx_s;
            end
            if (accept_s && state_s == ST_IDLE) begin
                ptr_r <= wrap_inc(grant_idx_s);
            end
        end
    end
`else
    // Per-beat arbitration: every valid queue is eligible.
    always_comb begin
        elig_s = in_valid;
    end

    // Round-robin pointer moves past each granted queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (accept_s) begin
            ptr_r <= wrap_inc(grant_idx_s);
        end
    end
`endif

    // Round-robin search starting at ptr_r, wrapping modulo QUEUE_COUNT.
    always_comb begin
        logic [IDX_W-1:0] scan_s;
        grant_idx_s = ptr_r;
        found_s     = 1'b0;
        scan_s      = ptr_r;
        for (int i = 0; i < QUEUE_COUNT; i++) begin
            if (!found_s && elig_s[scan_s]) begin
                found_s     = 1'b1;
                grant_idx_s = scan_s;
            end else begin
                found_s     = found_s;
            end
            scan_s = wrap_inc(scan_s);
        end
    end

    // Grant is only issued when the output register can take a beat and reset is low.
    always_comb begin
        load_s     = !out_valid_r || out_ready;
        ready_s    = '0;
        accept_s   = 1'b0;
        acc_last_s = in_last[grant_idx_s];
        if (!rst && load_s && found_s) begin
            ready_s[grant_idx_s] = 1'b1;
            accept_s             = 1'b1;
        end else begin
            ready_s  = '0;
            accept_s = 1'b0;
        end
    end

    // Output register: loads on accept, drains when downstream takes the beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r   <= 1'b0;
            out_payload_r <= '0;
            out_last_r    <= 1'b0;
            out_queue_r   <= '0;
        end else if (load_s) begin
            out_valid_r <= accept_s;
            if (accept_s) begin
                out_payload_r <= in_payload[grant_idx_s];
                out_last_r    <= acc_last_s;
                out_queue_r   <= grant_idx_s;
            end
        end
    end

    assign in_ready    = ready_s;
    assign out_valid   = out_valid_r;
    assign out_payload = out_payload_r;
    assign out_last    = out_last_r;
    assign out_queue   = out_queue_r;

endmodule

// File: tb/tb_multi_queue_rr_reader.sv
// Directed self-checking bench for multi_queue_rr_reader (QUEUE_COUNT=4, WIDTH=32).
module tb_multi_queue_rr_reader;

    logic             clk;
    logic             rst;
    logic [3:0]       in_valid;
    logic [3:0][31:0] in_payload;
    logic [3:0]       in_last;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [31:0]      out_payload;
    logic             out_last;
    logic [1:0]       out_queue;
    logic             out_ready;

    int tests = 0;
    int fails = 0;

    multi_queue_rr_reader #(.QUEUE_COUNT(4), .WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_payload(in_payload), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_payload(out_payload), .out_last(out_last),
        .out_queue(out_queue), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] p, input logic l, input logic [1:0] q);
        check({tag, ".valid"}, 64'(out_valid), 64'(v));
        check({tag, ".payload"}, 64'(out_payload), 64'(p));
        check({tag, ".last"}, 64'(out_last), 64'(l));
        check({tag, ".queue"}, 64'(out_queue), 64'(q));
    endtask

    initial begin
        int n1;
        logic [1:0] expq [4];
        rst        = 1'b1;
        in_valid   = 4'b0000;
        in_last    = 4'b0000;
        in_payload = '0;
        out_ready  = 1'b0;

        // Reset state; in_ready stays low while rst is high even with all queues valid.
        tick();
        tick();
        check_out("reset", 1'b0, 32'h0, 1'b0, 2'd0);
        in_valid = 4'b1111;
        in_last  = 4'b1111;
        in_payload[0] = 32'h1000; in_payload[1] = 32'h1111;
        in_payload[2] = 32'h2222; in_payload[3] = 32'h3333;
        #1;
        check("reset.in_ready", 64'(in_ready), 64'h0);

        // All queues valid: grants rotate 0,1,2,3,0 at one beat per cycle.
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr%0d.in_ready", k), 64'(in_ready), 64'(4'b0001 << (k % 4)));
            tick();
            check_out($sformatf("rr%0d", k), 1'b1, in_payload[k % 4], 1'b1, 2'(k % 4));
        end

        // Only queue 2 valid: payloads A,B,C pass in order.
        in_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            in_payload[2] = 32'hA + 32'(k);
            #1;
            check($sformatf("q2_%0d.in_ready", k), 64'(in_ready), 64'h4);
            tick();
            check_out($sformatf("q2_%0d", k), 1'b1, 32'hA + 32'(k), 1'b1, 2'd2);
        end

        // Nothing valid: out_valid drops next cycle.
        in_valid = 4'b0000;
        #1;
        check("idle.in_ready", 64'(in_ready), 64'h0);
        tick();
        check("idle.valid", 64'(out_valid), 64'h0);

        // Backpressure: 0x55 held for three stalled cycles, no grants meanwhile.
        out_ready     = 1'b0;
        in_valid      = 4'b0001;
        in_last       = 4'b1110;
        in_payload[0] = 32'h55;
        tick();
        check_out("bp_load", 1'b1, 32'h55, 1'b0, 2'd0);
        in_payload[0] = 32'h66;
        in_last       = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d.in_ready", k), 64'(in_ready), 64'h0);
            tick();
            check_out($sformatf("bp%0d", k), 1'b1, 32'h55, 1'b0, 2'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release.in_ready", 64'(in_ready), 64'h1);
        tick();
        check_out("bp_release", 1'b1, 32'h66, 1'b1, 2'd0);

        // Move pointer to 2, then reset with a beat held: beat discarded, pointer back to 0.
        in_valid = 4'b0010;
        tick();
        check_out("pre_rst", 1'b1, 32'h1111, 1'b1, 2'd1);
        rst      = 1'b1;
        in_valid = 4'b1010;
        #1;
        check("rst_mid.in_ready", 64'(in_ready), 64'h0);
        tick();
        check_out("rst_mid", 1'b0, 32'h0, 1'b0, 2'd0);
        rst = 1'b0;
        #1;
        check("post_rst.in_ready", 64'(in_ready), 64'h2);
        tick();
        check_out("post_rst", 1'b1, 32'h1111, 1'b1, 2'd1);

        // Set pointer to 1 with a queue-0 beat, then queue 1 sends a 3-beat packet while queue 0 waits.
        in_valid      = 4'b0001;
        in_payload[0] = 32'h200;
        tick();
        check_out("pkt_pre", 1'b1, 32'h200, 1'b1, 2'd0);
`ifdef MULTI_QUEUE_RR_READER_PACKET_LOCK_EN
        expq[0] = 2'd1; expq[1] = 2'd1; expq[2] = 2'd1; expq[3] = 2'd0;
`else
        expq[0] = 2'd1; expq[1] = 2'd0; expq[2] = 2'd1; expq[3] = 2'd0;
`endif
        in_valid = 4'b0011;
        n1 = 0;
        for (int k = 0; k < 4; k++) begin
            in_payload[1] = 32'h100 + 32'(n1);
            in_last[1]    = (n1 == 2);
            #1;
            check($sformatf("pkt%0d.in_ready", k), 64'(in_ready), 64'(4'b0001 << expq[k]));
            tick();
            check_out($sformatf("pkt%0d", k), 1'b1,
                      (expq[k] == 2'd1) ? 32'h100 + 32'(n1) : 32'h200,
                      (expq[k] == 2'd1) ? (n1 == 2) : 1'b1, expq[k]);
            if (expq[k] == 2'd1) n1++;
        end

        // Queue 2 starts a packet then stalls; with locking the block waits for it.
        in_valid      = 4'b0100;
        in_last       = 4'b1011;
        in_payload[2] = 32'h300;
        #1;
        check("gap0.in_ready", 64'(in_ready), 64'h4);
        tick();
        check_out("gap0", 1'b1, 32'h300, 1'b0, 2'd2);
        in_valid = 4'b0001;
        #1;
`ifdef MULTI_QUEUE_RR_READER_PACKET_LOCK_EN
        check("gap1.in_ready", 64'(in_ready), 64'h0);
        tick();
        check("gap1.valid", 64'(out_valid), 64'h0);
`else
        check("gap1.in_ready", 64'(in_ready), 64'h1);
        tick();
        check_out("gap1", 1'b1, 32'h200, 1'b1, 2'd0);
`endif
        in_valid      = 4'b0101;
        in_last       = 4'b1111;
        in_payload[2] = 32'h301;
        #1;
        check("gap2.in_ready", 64'(in_ready), 64'h4);
        tick();
        check_out("gap2", 1'b1, 32'h301, 1'b1, 2'd2);
        in_valid = 4'b0001;
        #1;
        check("gap3.in_ready", 64'(in_ready), 64'h1);
        tick();
        check_out("gap3", 1'b1, 32'h200, 1'b1, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // onehot0 of in_ready is sampled on every falling edge for the whole run.
    always @(negedge clk) begin
        tests++;
        assert ($onehot0(in_ready)) else begin
            fails++;
            $error("FAIL onehot0: observed %b expected onehot0", in_ready);
        end
    end

endmodule

// File: doc/multi_queue_rr_reader.md
MULTI_QUEUE_RR_READER -- requirements
Module: multi_queue_rr_reader

Interface
REQ-001 The block SHALL have parameter QUEUE_COUNT, default 4, meaning the number of input queues, legal range 2..16.
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning the payload width in bits, minimum 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, QUEUE_COUNT bits: per-queue beat available.
REQ-006 The block SHALL have port in_payload, input, QUEUE_COUNT x WIDTH bits: per-queue beat data.
REQ-007 The block SHALL have port in_last, input, QUEUE_COUNT bits: per-queue end-of-packet marker.
REQ-008 The block SHALL have port in_ready, output, QUEUE_COUNT bits: per-queue beat accepted when ANDed with in_valid.
REQ-009 The block SHALL have port out_valid, output, 1 bit: registered output beat present.
REQ-010 The block SHALL have port out_payload, output, WIDTH bits: registered output data.
REQ-011 The block SHALL have port out_last, output, 1 bit: registered end-of-packet marker.
REQ-012 The block SHALL have port out_queue, output, $clog2(QUEUE_COUNT) bits: source-queue index of the output beat.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the output beat.

Function
REQ-014 Transfers SHALL occur on a side only in cycles where valid and ready are both high; valid SHALL NOT depend combinationally on ready.
REQ-015 in_ready SHALL be onehot0 in every cycle, including reset cycles.
REQ-016 The load condition SHALL be (!out_valid || out_ready); when it is low, all in_ready bits SHALL be 0.
REQ-017 The grant SHALL be round-robin: search starts at rr_ptr and wraps modulo QUEUE_COUNT; the first queue with in_valid high gets in_ready when the load condition holds.
REQ-018 in_ready[i] SHALL NOT depend combinationally on in_valid[i]'s own payload or last inputs.
REQ-019 An accepted beat SHALL appear on out_* in the next cycle (latency 1); out_queue SHALL equal the granted index.
REQ-020 The output register SHALL hold out_payload, out_last and out_queue stable while out_valid && !out_ready.
REQ-021 Throughput SHALL be one beat per cycle when out_ready is held high and at least one in_valid is high.
REQ-022 After an accepted beat from queue g, when not locked, rr_ptr SHALL become (g+1) mod QUEUE_COUNT, with wrap from QUEUE_COUNT-1 to 0.
REQ-023 When out_ready is high and no input is granted, out_valid SHALL fall to 0 in the next cycle.
REQ-024 Fairness: a queue holding in_valid continuously SHALL be granted within QUEUE_COUNT accepted beats; this holds per packet when locked.
REQ-025 Beats from one queue SHALL leave in the same order they were accepted.

Reset
REQ-026 While rst is high, at the next edge: out_valid=0, out_payload=0, out_last=0, out_queue=0, rr_ptr=0, lock state=IDLE.
REQ-027 Beats held in the output register when rst asserts SHALL be discarded.
REQ-028 in_ready SHALL be all-zero in any cycle where rst is high.

Configuration
REQ-029 With macro MULTI_QUEUE_RR_READER_PACKET_LOCK_EN defined, the block SHALL use a two-state FSM, IDLE and LOCKED.
REQ-030 In IDLE, accepting a beat with in_last=0 SHALL move the FSM to LOCKED on the granted queue.
REQ-031 In LOCKED, only the locked queue SHALL be eligible for grant, and rr_ptr SHALL not advance.
REQ-032 In LOCKED, accepting a beat with in_last=1 SHALL return the FSM to IDLE and set rr_ptr to (locked+1) mod QUEUE_COUNT.
REQ-033 In LOCKED, if the locked queue deasserts in_valid, the block SHALL grant nothing and SHALL wait.
REQ-034 Accepting a beat with in_last=1 in IDLE SHALL leave the FSM in IDLE.
REQ-035 Without MULTI_QUEUE_RR_READER_PACKET_LOCK_EN, arbitration SHALL occur per beat; in_last SHALL be passed through only, and the FSM logic SHALL be absent.

Verification
REQ-036 Reset, then in_valid=4'b1111 with all in_last=1 and out_ready=1 -> out_queue sequence 0,1,2,3,0 on consecutive cycles, out_valid constantly 1 from cycle 1.
REQ-037 Only queue 2 valid with payloads 0xA,0xB,0xC and out_ready=1 -> out_payload 0xA,0xB,0xC on cycles 1..3; in_ready == 4'b0100 throughout.
REQ-038 out_valid=1 with out_payload=0x55 and out_ready=0 for 3 cycles -> out_* stable; in_ready == 0 for those 3 cycles.
REQ-039 With LOCK_EN, queue 1 sends a 3-beat packet (last on beat 3) while queue 0 is valid -> three queue-1 beats back-to-back, then queue 0 granted.
REQ-040 rst asserted for 1 cycle while out_valid=1 -> out_valid=0 and rr_ptr=0 next cycle; the next grant goes to the lowest valid index.
REQ-041 A formal harness SHALL assert onehot0(in_ready) and per-queue FIFO order through a tracker, and cover sustained 1 beat/cycle.
